// File: rtl/mem_wb_pkg.sv
// mem_wb_pkg: shared widths, default depth and write-enable control struct for the mem->wb pipe
package mem_wb_pkg;
  localparam int MEMWB_DATAW = 16;
  localparam int MEMWB_ADDRW = 32;
  localparam int MEMWB_DEPTH_DEF = 2;
  typedef struct packed {
    logic fft_wr_en;
    logic reg_wr_en;
  } memwb_ctrl_t;
endpackage

// File: rtl/memwb_skid_buf.sv
// memwb_skid_buf: one-entry skid register (load d, drain, flush/rst clear) exposing valid and q
module memwb_skid_buf
  import mem_wb_pkg::*;
#(
  parameter int W = MEMWB_ADDRW + MEMWB_DATAW + 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         load,
  input  logic         drain,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid <= 1'b0;
      q <= '0;
    end else if (load) begin
      valid <= 1'b1;
      q <= d;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/mem_wb_elastic_pipe.sv
// mem_wb_elastic_pipe: DEPTH-stage valid/ready mem->wb pipe with bubble collapse, optional skid, flush; in_*/out_* handshake + occupancy
module mem_wb_elastic_pipe
  import mem_wb_pkg::*;
#(
  parameter int DATAW = MEMWB_DATAW,
  parameter int ADDRW = MEMWB_ADDRW,
  parameter int DEPTH = MEMWB_DEPTH_DEF,
  parameter int SKID = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_fft_wr_en,
  input  logic                       in_reg_wr_en,
  input  logic [ADDRW-1:0]           in_addr,
  input  logic [DATAW-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_fft_wr_en,
  output logic                       out_reg_wr_en,
  output logic [ADDRW-1:0]           out_addr,
  output logic [DATAW-1:0]           out_data,
  output logic [$clog2(DEPTH+2)-1:0] occupancy
);
  localparam int PW = ADDRW + DATAW + 2;
  localparam int OW = $clog2(DEPTH + 2);
  logic [DEPTH-1:0] valid, take, prev_v;
  logic [PW-1:0] pay [DEPTH];
  logic [PW-1:0] prev_p [DEPTH];
  logic [PW-1:0] in_pay, src_pay;
  logic src_valid, skid_valid;
  memwb_ctrl_t head_ctrl;
  assign in_pay = {in_fft_wr_en, in_reg_wr_en, in_addr, in_data};
  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    assign take[k] = out_ready || !(&valid[DEPTH-1:k]);
    if (k == 0) begin : g_first
      assign prev_v[k] = src_valid;
      assign prev_p[k] = src_pay;
    end else begin : g_chain
      assign prev_v[k] = valid[k-1];
      assign prev_p[k] = pay[k-1];
    end
  end
  if (SKID != 0) begin : g_skid
    logic [PW-1:0] skid_pay;
    memwb_skid_buf #(.W(PW)) u_skid (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .load  (in_valid && !skid_valid && !take[0]),
      .drain (take[0] && skid_valid),
      .d     (in_pay),
      .valid (skid_valid),
      .q     (skid_pay)
    );
    assign in_ready = !skid_valid;
    assign src_valid = skid_valid || in_valid;
    assign src_pay = skid_valid ? skid_pay : in_pay;
  end else begin : g_direct
    assign skid_valid = 1'b0;
    assign in_ready = take[0];
    assign src_valid = in_valid;
    assign src_pay = in_pay;
  end
  always_ff @(posedge clk) begin
    for (int k = 0; k < DEPTH; k++) begin
      if (rst || flush) begin
        valid[k] <= 1'b0;
        pay[k] <= '0;
      end else if (take[k]) begin
        valid[k] <= prev_v[k];
        pay[k] <= prev_p[k];
      end
    end
  end
  always_comb begin
    occupancy = OW'(skid_valid);
    for (int k = 0; k < DEPTH; k++) occupancy = occupancy + OW'(valid[k]);
  end
  assign head_ctrl = pay[DEPTH-1][PW-1 -: 2];
  assign {out_addr, out_data} = pay[DEPTH-1][PW-3:0];
  assign out_fft_wr_en = head_ctrl.fft_wr_en;
  assign out_reg_wr_en = head_ctrl.reg_wr_en;
  assign out_valid = valid[DEPTH-1];
endmodule
